// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus arbiter.
//   state_t  - transaction FSM states (IDLE / ISSUE / WAIT)
//   OWN_*    - encoding of the debug owner field and of 2-bit grant vectors
//              (bit 0 = IFU, bit 1 = LSU)
//   *_DEF    - default address/data widths
package mem_bus_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IFU  = 2'b01;
   localparam logic [1:0] OWN_LSU  = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin grant.
//   clk, rst - clock, asynchronous active-low reset
//   en       - arbitration allowed this cycle (grant forced to 0 otherwise)
//   req      - request vector, bit 0 = IFU, bit 1 = LSU
//   gnt      - one-hot grant (combinational), same bit order as req
// Every non-zero grant is taken as a handshake (grant only goes to a valid
// requester), so the last-grant pointer advances on any grant.
module rr_arbiter2
   import mem_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // 0 = IFU won last, 1 = LSU won last; reset to IFU so the first
   // contention goes to the LSU.
   logic last_lsu;

   always_comb begin
      gnt = OWN_NONE;
      if (en) begin
         case (req)
            2'b01:   gnt = OWN_IFU;
            2'b10:   gnt = OWN_LSU;
            2'b11:   gnt = last_lsu ? OWN_IFU : OWN_LSU;
            default: gnt = OWN_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_lsu <= 1'b0;
      else if (|gnt)
         last_lsu <= gnt[1];
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the IFU (read-only) and
// the LSU (read/write). One outstanding transaction, round-robin grant,
// response watchdog that answers with an error when memory stalls.
//   clk, rst          - clock, asynchronous active-low reset
//   ifu_req_* / ifu_addr, ifu_rsp_*         - fetch master
//   lsu_req_* / lsu_addr/wen/wdata/wmask, lsu_rsp_* - load/store master
//   mem_req_* / mem_addr/wen/wdata/wmask, mem_rsp_* - memory port
//   owner             - debug: 00 none, 01 IFU, 10 LSU
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata,
   output logic [1:0]          owner
);

   localparam int MASK_W = DATA_W / 8;
   // The counter clears at the grant edge and first counts in the ISSUE
   // cycle, so it reaches TIMEOUT at the end of cycle TIMEOUT after grant.
   // Expiry is flagged in that cycle, i.e. while it still reads TIMEOUT-1.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_wen;
   logic [DATA_W-1:0]   lat_wdata;
   logic [MASK_W-1:0]   lat_wmask;
   logic [CNT_W-1:0]    wd;
   logic [1:0]          gnt;
   logic                arb_en, busy, expire, rsp_ok, rsp_err, rsp_fire;
   logic [DATA_W-1:0]   rsp_data;

   // Grants are only offered in IDLE and never while reset is held, so no
   // ready can be seen during reset even with a master requesting.
   assign arb_en = (state == IDLE) && rst;

   rr_arbiter2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req ({lsu_req_valid, ifu_req_valid}),
      .gnt (gnt)
   );

   assign busy     = (state == ISSUE) || (state == WAIT);
   assign expire   = (TIMEOUT != 0) && busy && (wd == WD_LAST);
   // A real response in WAIT always beats a simultaneous expiry; responses
   // outside WAIT are stray and dropped.
   assign rsp_ok   = (state == WAIT) && mem_rsp_valid;
   assign rsp_err  = expire && !rsp_ok;
   assign rsp_fire = rsp_ok || rsp_err;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (|gnt) state_nxt = ISSUE;
         ISSUE: begin
            if (expire)             state_nxt = IDLE;
            else if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT:  if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, owner and watchdog
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= OWN_NONE;
         lat_addr  <= '0;
         lat_wen   <= 1'b0;
         lat_wdata <= '0;
         lat_wmask <= '0;
         wd        <= '0;
      end else if (|gnt) begin
         owner <= gnt;
         wd    <= '0;
         if (gnt[1]) begin
            lat_addr  <= lsu_addr;
            lat_wen   <= lsu_wen;
            lat_wdata <= lsu_wdata;
            lat_wmask <= lsu_wmask;
         end else begin
            lat_addr  <= ifu_addr;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= '0;
         end
      end else if (busy) begin
         wd <= wd + 1'b1;
         if (state_nxt == IDLE)
            owner <= OWN_NONE;
      end
   end

   // Output logic
   always_comb begin
      ifu_req_ready = gnt[0];
      lsu_req_ready = gnt[1];

      // Valid drops in the expiry cycle so a late ready cannot complete a
      // handshake for a transaction that has already been errored out.
      mem_req_valid = (state == ISSUE) && !expire;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      if (state == ISSUE) begin
         mem_addr  = lat_addr;
         mem_wen   = lat_wen;
         mem_wdata = lat_wdata;
         mem_wmask = lat_wmask;
      end

      // Stores and errors return zero data.
      rsp_data = (rsp_ok && !lat_wen) ? mem_rsp_rdata : '0;

      ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
      ifu_rsp_err   = rsp_err  && (owner == OWN_IFU);
      ifu_rsp_data  = (owner == OWN_IFU) ? rsp_data : '0;
      lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
      lsu_rsp_err   = rsp_err  && (owner == OWN_LSU);
      lsu_rsp_data  = (owner == OWN_LSU) ? rsp_data : '0;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=8). Each vector row holds the
// inputs for one cycle and the outputs expected in that same cycle.
module tb_mem_bus_arbiter;

   localparam logic [31:0] IFU_A = 32'h8000_0000;
   localparam logic [31:0] LSU_A = 32'h8000_1000;
   localparam logic [31:0] WD    = 32'hA5A5_A5A5;
   localparam logic [3:0]  WM    = 4'hF;

   logic        clk, rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_addr, ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
   logic [3:0]  mem_wmask;
   logic [1:0]  owner;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [159:0] all_out;
   assign all_out = 160'({ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
                          lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
                          mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, owner});

   typedef struct {
      logic        ifu_v, lsu_v, wen, mrdy, mrsp;
      logic [31:0] rdata;
      logic [1:0]  e_rdy;   // {lsu_ready, ifu_ready}
      logic [1:0]  e_irsp;  // {ifu_rsp_valid, ifu_rsp_err}
      logic [1:0]  e_lrsp;  // {lsu_rsp_valid, lsu_rsp_err}
      logic [31:0] e_data;  // data of whichever response is valid
      logic        e_mreq;
      logic [1:0]  e_own;
   } vec_t;

   function automatic vec_t R(input logic iv, input logic lv, input logic wn,
                              input logic mr, input logic ms, input logic [31:0] rd,
                              input logic [1:0] er, input logic [1:0] ei,
                              input logic [1:0] el, input logic [31:0] ed,
                              input logic em, input logic [1:0] eo);
      vec_t v;
      v.ifu_v = iv; v.lsu_v = lv; v.wen = wn; v.mrdy = mr; v.mrsp = ms; v.rdata = rd;
      v.e_rdy = er; v.e_irsp = ei; v.e_lrsp = el; v.e_data = ed; v.e_mreq = em; v.e_own = eo;
      return v;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      ifu_req_valid = v.ifu_v;
      lsu_req_valid = v.lsu_v;
      lsu_wen       = v.wen;
      mem_req_ready = v.mrdy;
      mem_rsp_valid = v.mrsp;
      mem_rsp_rdata = v.rdata;
      #2;
      check({tag, " ctl"},
            160'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, ifu_rsp_err,
                  lsu_rsp_valid, lsu_rsp_err, mem_req_valid, owner}),
            160'({v.e_rdy[0], v.e_rdy[1], v.e_irsp, v.e_lrsp, v.e_mreq, v.e_own}));
      if (v.e_irsp[1]) check({tag, " ifu data"}, 160'(ifu_rsp_data), 160'(v.e_data));
      if (v.e_lrsp[1]) check({tag, " lsu data"}, 160'(lsu_rsp_data), 160'(v.e_data));
      if (v.e_mreq) begin
         if (v.e_own == 2'b01)
            check({tag, " mem ifu"}, 160'({mem_addr, mem_wen, mem_wmask}),
                  160'({IFU_A, 1'b0, 4'h0}));
         else
            check({tag, " mem lsu"}, 160'({mem_addr, mem_wen, mem_wdata, mem_wmask}),
                  160'({LSU_A, v.wen, WD, WM}));
      end
   endtask

   vec_t tbl[$];

   initial begin
      // Round-robin contention right after reset, then a single fetch, then
      // a store with memory back-pressure and stray responses.
      tbl.push_back(R(1,1,0,0,0,0,            2'b10,0,0,0,0,2'b00));
      tbl.push_back(R(1,1,0,1,0,0,            2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(1,1,0,0,1,32'h11111111, 2'b00,0,2'b10,32'h11111111,0,2'b10));
      tbl.push_back(R(1,1,0,0,0,0,            2'b01,0,0,0,0,2'b00));
      tbl.push_back(R(1,1,0,1,0,0,            2'b00,0,0,0,1,2'b01));
      tbl.push_back(R(1,1,0,0,1,32'h22222222, 2'b00,2'b10,0,32'h22222222,0,2'b01));
      tbl.push_back(R(1,1,0,0,0,0,            2'b10,0,0,0,0,2'b00));
      tbl.push_back(R(0,0,0,1,0,0,            2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(0,0,0,0,1,32'h33333333, 2'b00,0,2'b10,32'h33333333,0,2'b10));
      tbl.push_back(R(0,0,0,0,0,0,            2'b00,0,0,0,0,2'b00));
      tbl.push_back(R(1,0,0,0,0,0,            2'b01,0,0,0,0,2'b00));
      tbl.push_back(R(0,0,0,1,0,0,            2'b00,0,0,0,1,2'b01));
      tbl.push_back(R(0,0,0,0,1,32'h00100073, 2'b00,2'b10,0,32'h00100073,0,2'b01));
      tbl.push_back(R(0,0,0,0,0,0,            2'b00,0,0,0,0,2'b00));
      tbl.push_back(R(0,1,1,0,0,0,            2'b10,0,0,0,0,2'b00));
      tbl.push_back(R(0,0,1,0,0,0,            2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(0,0,1,0,1,32'hDEAD0000, 2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(0,0,1,0,0,0,            2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(0,0,1,1,0,0,            2'b00,0,0,0,1,2'b10));
      tbl.push_back(R(0,0,1,0,1,32'hFFFFFFFF, 2'b00,0,2'b10,0,0,2'b10));
      tbl.push_back(R(0,0,0,0,1,32'h55555555, 2'b00,0,0,0,0,2'b00));

      rst = 1'b0;
      ifu_addr = IFU_A; lsu_addr = LSU_A; lsu_wdata = WD; lsu_wmask = WM;
      ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
      repeat (2) @(negedge clk);
      ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1;
      mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEADBEEF;
      #1;
      check("reset outputs", all_out, '0);
      ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      @(negedge clk) rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i], $sformatf("row%0d", i));

      // IFU fetch, memory never answers: error 8 cycles after grant.
      step(R(1,0,0,0,0,0, 2'b01,0,0,0,0,2'b00), "to_wait c0");
      step(R(0,0,0,1,0,0, 2'b00,0,0,0,1,2'b01), "to_wait c1");
      for (int k = 2; k <= 7; k++)
         step(R(0,0,0,0,0,0, 2'b00,0,0,0,0,2'b01), $sformatf("to_wait c%0d", k));
      step(R(0,0,0,0,0,0, 2'b00,2'b11,0,0,0,2'b01), "to_wait c8");
      step(R(0,0,0,0,1,32'h12345678, 2'b00,0,0,0,0,2'b00), "to_wait stray");

      // LSU load whose response lands exactly on expiry: real data wins.
      step(R(0,1,0,0,0,0, 2'b10,0,0,0,0,2'b00), "tie c0");
      step(R(0,0,0,1,0,0, 2'b00,0,0,0,1,2'b10), "tie c1");
      for (int k = 2; k <= 7; k++)
         step(R(0,0,0,0,0,0, 2'b00,0,0,0,0,2'b10), $sformatf("tie c%0d", k));
      step(R(0,0,0,0,1,32'hCAFEBABE, 2'b00,0,2'b10,32'hCAFEBABE,0,2'b10), "tie c8");
      step(R(0,0,0,0,0,0, 2'b00,0,0,0,0,2'b00), "tie c9");

      // LSU store never accepted by memory: expiry while still in ISSUE.
      step(R(0,1,1,0,0,0, 2'b10,0,0,0,0,2'b00), "to_issue c0");
      for (int k = 1; k <= 7; k++)
         step(R(0,0,1,0,0,0, 2'b00,0,0,0,1,2'b10), $sformatf("to_issue c%0d", k));
      step(R(0,0,1,0,0,0, 2'b00,0,2'b11,0,0,2'b10), "to_issue c8");
      step(R(0,0,0,1,0,0, 2'b00,0,0,0,0,2'b00), "to_issue c9");

      // Reset asserted in WAIT, then a clean fetch afterwards.
      step(R(1,0,0,0,0,0, 2'b01,0,0,0,0,2'b00), "rst c0");
      step(R(1,0,0,1,0,0, 2'b00,0,0,0,1,2'b01), "rst c1");
      @(negedge clk);
      #1 rst = 1'b0;
      #1 mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BADF00D;
      #1;
      check("reset in wait", all_out, '0);
      ifu_req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 0;
      @(negedge clk) rst = 1'b1;
      step(R(1,0,0,0,0,0, 2'b01,0,0,0,0,2'b00), "post_rst c0");
      step(R(0,0,0,1,0,0, 2'b00,0,0,0,1,2'b01), "post_rst c1");
      step(R(0,0,0,0,1,32'h00000013, 2'b00,2'b10,0,32'h00000013,0,2'b01), "post_rst c2");
      step(R(0,0,0,0,0,0, 2'b00,0,0,0,0,2'b00), "post_rst c3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
